// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / forwarding control for the 5-stage RISC-V pipeline.
//
// Optional feature macro: HAZARD_MEM_WAIT_EN
//   defined   -> a data-memory wait (dmem_req_m & ~dmem_ready) freezes the whole
//                pipeline up to M and bubbles W.
//   undefined -> memory wait is disabled; dmem_req_m / dmem_ready are ignored,
//                stall_m and flush_w are always 0.
//
// Event priority: memory wait > multi-cycle execute > taken branch > load-use.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// RUN     | normal flow; a multi-cycle op entering E starts the occupancy
// MC_WAIT | multi-cycle op held in E; cnt counts the remaining stall cycles

module hazard_ctrl #(
  parameter int MC_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       load_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       pc_src_e,
  input  logic       mc_start_e,
  input  logic       dmem_req_m,
  input  logic       dmem_ready,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_m,
  output logic       flush_w,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       mc_busy
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MC_WAIT = 1'b1;

  // A latency of 1 completes in a single E cycle, so no occupancy is tracked.
  localparam bit         MC_MULTI  = (MC_LATENCY >= 2);
  localparam int         MC_LOAD_I = MC_MULTI ? (MC_LATENCY - 2) : 0;
  localparam logic [3:0] MC_LOAD   = MC_LOAD_I[3:0];

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  logic [0:0] state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       mw;
  logic       mc_go;
  logic       load_use;

`ifdef HAZARD_MEM_WAIT_EN
  assign mw = dmem_req_m & ~dmem_ready;
`else
  // Ports kept for a uniform footprint; they have no effect in this build.
  logic unused_dmem;
  assign unused_dmem = dmem_req_m ^ dmem_ready;
  assign mw = 1'b0;
`endif

  // A multi-cycle op only starts occupancy from RUN; while held it keeps
  // asserting mc_start_e, which must not retrigger the sequence.
  assign mc_go    = MC_MULTI & mc_start_e & (state == RUN);
  assign load_use = load_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
  assign mc_busy  = (state == MC_WAIT);

  // Operand forwarding: newest producer (M) wins over W; x0 never forwards.
  always_comb begin
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rs1_e == rd_m))
      forward_a_e = FWD_M;
    else if (reg_write_w && (rd_w != 5'd0) && (rs1_e == rd_w))
      forward_a_e = FWD_W;
    if (reg_write_m && (rd_m != 5'd0) && (rs2_e == rd_m))
      forward_b_e = FWD_M;
    else if (reg_write_w && (rd_w != 5'd0) && (rs2_e == rd_w))
      forward_b_e = FWD_W;
  end

  // Next-state and counter; everything holds while memory wait is active.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (!mw) begin
      case (state)
        RUN: begin
          if (mc_go) begin
            state_nx = MC_WAIT;
            cnt_nx   = MC_LOAD;
          end
        end
        MC_WAIT: begin
          if (cnt != 4'd0)
            cnt_nx = cnt - 4'd1;
          else
            state_nx = RUN;
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = 4'd0;
        end
      endcase
    end
  end

  // State and occupancy counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Stall/flush decode in priority order; all quiet while reset is high.
  // The release cycle of a multi-cycle op (MC_WAIT, cnt == 0) is deliberately
  // silent so that E is never flushed underneath the held op.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (!reset) begin
      if (mw) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (state == MC_WAIT) begin
        if (cnt != 4'd0) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
        end
      end else if (mc_go) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios followed by randomized traffic,
// all checked against an occupancy-count reference model.
module tb_hazard_ctrl;

  localparam int L = 4;
`ifdef HAZARD_MEM_WAIT_EN
  localparam bit MWEN = 1'b1;
`else
  localparam bit MWEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       load_e, reg_write_m, reg_write_w, pc_src_e, mc_start_e;
  logic       dmem_req_m, dmem_ready;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_m, flush_w;
  logic [1:0] forward_a_e, forward_b_e;
  logic       mc_busy;

  hazard_ctrl #(.MC_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m(rd_m), .rd_w(rd_w), .load_e(load_e),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .pc_src_e(pc_src_e), .mc_start_e(mc_start_e),
    .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .mc_busy(mc_busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         busy_left = 0;   // E cycles the held op still needs, release cycle included
  logic [7:0] last_ctl;        // {stall_f,d,e,m, flush_d,e,m,w} sampled at last step
  logic       last_busy;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rs == rd_m) return 2'd2;
    if (reg_write_w && rd_w != 0 && rs == rd_w) return 2'd1;
    return 2'd0;
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance.
  task automatic step();
    logic [7:0] ectl;
    logic       mwx, lu, go;
    int         nb;
    @(negedge clk);
    mwx  = MWEN && dmem_req_m && !dmem_ready;
    lu   = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    go   = mc_start_e && (L >= 2);
    ectl = 8'h00;
    if (reset)              ectl = 8'h00;
    else if (mwx)           ectl = 8'b1111_0001;
    else if (busy_left > 1) ectl = 8'b1110_0010;
    else if (busy_left == 1) ectl = 8'h00;
    else if (go)            ectl = 8'b1110_0010;
    else if (pc_src_e)      ectl = 8'b0000_1100;
    else if (lu)            ectl = 8'b1100_0100;
    last_ctl  = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w};
    last_busy = mc_busy;
    chk("ctl", last_ctl, ectl);
    chk("mc_busy", {7'd0, mc_busy}, (!reset && busy_left > 0) ? 8'd1 : 8'd0);
    chk("fwd_a", {6'd0, forward_a_e}, {6'd0, fwd_ref(rs1_e)});
    chk("fwd_b", {6'd0, forward_b_e}, {6'd0, fwd_ref(rs2_e)});
    if (reset)              nb = 0;
    else if (mwx)           nb = busy_left;
    else if (busy_left > 0) nb = busy_left - 1;
    else if (go)            nb = L - 1;
    else                    nb = 0;
    @(posedge clk);
    #1;
    busy_left = nb;
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    load_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0; mc_start_e = 0;
    dmem_req_m = 0; dmem_ready = 1;
  endtask

  initial begin
    int n_st, n_bs, occ, n_mw;
    idle();
    reset = 1'b1;
    step();
    step();
    chk("reset_ctl", last_ctl, 8'h00);
    chk("reset_busy", {7'd0, last_busy}, 8'd0);
    reset = 1'b0;
    step();

    // Forwarding priority and x0 handling
    rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1; rs1_e = 5; rs2_e = 0;
    step();
    chk("fwd_m_prio", {6'd0, forward_a_e}, 8'd2);
    chk("fwd_b_x0", {6'd0, forward_b_e}, 8'd0);
    rd_m = 0;
    step();
    chk("fwd_w", {6'd0, forward_a_e}, 8'd1);
    idle();

    // Load-use, then load-use masked by a taken branch
    load_e = 1; rd_e = 3; rs2_d = 3;
    step();
    chk("load_use", last_ctl, 8'b1100_0100);
    load_e = 0;
    step();
    chk("load_use_once", last_ctl, 8'h00);
    load_e = 1; pc_src_e = 1;
    step();
    chk("branch_over_lu", last_ctl, 8'b0000_1100);
    idle();
    step();

    // Multi-cycle op: 3 stall cycles, 3 busy cycles, release on the 4th
    n_st = 0; n_bs = 0;
    mc_start_e = 1;
    for (int i = 0; i < L; i++) begin
      step();
      if (last_ctl[5]) n_st++;
      if (last_busy) n_bs++;
    end
    chk("mc_release", last_ctl, 8'h00);
    chk("mc_stalls", 8'(n_st), 8'd3);
    chk("mc_busy_cycles", 8'(n_bs), 8'd3);
    mc_start_e = 0;
    step();
    chk("mc_after", {7'd0, last_busy}, 8'd0);

    // Memory wait for 2 cycles in the middle of a multi-cycle op
    occ = 0; n_mw = 0;
    mc_start_e = 1; dmem_req_m = 1;
    for (int i = 0; i < 20; i++) begin
      dmem_ready = !(i == 1 || i == 2);
      step();
      occ++;
      if (last_ctl[4] && last_ctl[0]) n_mw++;
      if (!last_ctl[5]) break;
    end
    chk("mw_occupancy", 8'(occ), MWEN ? 8'd6 : 8'd4);
    chk("mw_cycles", 8'(n_mw), MWEN ? 8'd2 : 8'd0);
    idle();
    step();

`ifndef HAZARD_MEM_WAIT_EN
    // Memory wait disabled: a permanently stalled memory is ignored
    occ = 0; n_mw = 0;
    mc_start_e = 1; dmem_req_m = 1; dmem_ready = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      occ++;
      if (last_ctl[4] || last_ctl[0]) n_mw++;
      if (!last_ctl[5]) break;
    end
    chk("nomw_occupancy", 8'(occ), 8'd4);
    chk("nomw_stall_m", 8'(n_mw), 8'd0);
    idle();
    step();
`endif

    // Reset during MC_WAIT with one stall cycle left, then a clean restart
    mc_start_e = 1;
    step();
    step();
    reset = 1;
    step();
    chk("rst_mid_ctl", last_ctl, 8'h00);
    chk("rst_mid_busy", {7'd0, last_busy}, 8'd0);
    reset = 0;
    n_st = 0;
    for (int i = 0; i < L; i++) begin
      step();
      if (last_ctl[5]) n_st++;
    end
    chk("rst_restart_stalls", 8'(n_st), 8'd3);
    idle();
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs1_d = 5'($urandom_range(3)); rs2_d = 5'($urandom_range(3));
      rs1_e = 5'($urandom_range(3)); rs2_e = 5'($urandom_range(3));
      rd_e  = 5'($urandom_range(3)); rd_m  = 5'($urandom_range(3));
      rd_w  = 5'($urandom_range(3));
      load_e      = ($urandom_range(2) == 0);
      reg_write_m = $urandom_range(1) != 0;
      reg_write_w = $urandom_range(1) != 0;
      pc_src_e    = ($urandom_range(3) == 0);
      mc_start_e  = (busy_left > 0) || ($urandom_range(7) == 0);
      dmem_req_m  = $urandom_range(1) != 0;
      dmem_ready  = ($urandom_range(3) != 0);
      reset       = ($urandom_range(99) == 0);
      step();
    end
    reset = 0;
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
